// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared framing definitions for the serial transmit and receive sides
package serial_pkg;

  localparam int DEFAULT_BIT_LEN = 7;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } tx_state_t;

  // Even parity over a zero-extended word; padding zeros do not change the XOR.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // Take the first set request at or above the pointer, wrapping past the top.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (enable && !any_grant && req[wrap_idx(int'(ptr), k)]) begin
        grant[wrap_idx(int'(ptr), k)] = 1'b1;
        grant_idx = IDX_W'(wrap_idx(int'(ptr), k));
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin shared serial transmitter with parity framing
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int BIT_LEN    = DEFAULT_BIT_LEN,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_LEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         channel_out,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         frame_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BIT_LEN + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_t          state;
  logic [BIT_LEN-1:0] shreg;
  logic [BIT_LEN-1:0] sel_word;
  logic               parity_bit;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_any;
  logic               arb_en;

  // Grants are only offered while idle; gating with rstn keeps req_ready low in reset.
  assign arb_en    = (state == ST_IDLE) && rstn;
  assign req_ready = arb_grant;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Mux the granted requester's word using the one-hot grant.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_word = sel_word | req_data[i*BIT_LEN +: BIT_LEN];
    end
  end

  // Frame sequencer: all wire-facing outputs are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ptr         <= '0;
      grant_id    <= '0;
      channel_out <= IDLE_LEVEL;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          channel_out <= IDLE_LEVEL;
          if (arb_any) begin
            shreg       <= sel_word;
            parity_bit  <= even_parity(32'(sel_word));
            grant_id    <= arb_idx;
            ptr         <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            channel_out <= START_BIT;
            busy        <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          channel_out <= shreg[0];
          shreg       <= shreg >> 1;
          bit_cnt     <= '0;
          state       <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == CNT_W'(BIT_LEN - 1)) begin
            channel_out <= parity_bit;
            state       <= ST_PARITY;
          end else begin
            channel_out <= shreg[0];
            shreg       <= shreg >> 1;
            bit_cnt     <= bit_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          channel_out <= STOP_BIT;
          frame_done  <= 1'b1;
          state       <= ST_STOP;
        end
        ST_STOP: begin
          channel_out <= IDLE_LEVEL;
          gap_cnt     <= '0;
          state       <= ST_GAP;
        end
        ST_GAP: begin
          channel_out <= IDLE_LEVEL;
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          channel_out <= IDLE_LEVEL;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed self-checking bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [27:0] req_data;
  logic [3:0]  req_ready;
  logic        channel_out;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  serial_tx_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .channel_out (channel_out),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [6:0] w);
    req_data[i*7 +: 7] = w;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Called at the negedge before the grant edge; walks the 11 wire cycles that follow,
  // drives valid_after on the first of them, and decodes the frame like the receiver.
  task automatic expect_frame(input logic [6:0] w, input logic [1:0] id,
                              input logic par, input logic [3:0] valid_after);
    logic [10:0] exp_bits;
    logic [10:0] bits;
    exp_bits[0] = 1'b1;
    for (int i = 0; i < 7; i++) exp_bits[1+i] = w[i];
    exp_bits[8]  = par;
    exp_bits[9]  = 1'b1;
    exp_bits[10] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = valid_after;
      #1;
      bits[k-1] = channel_out;
      check($sformatf("id%0d_line_t%0d", id, k), channel_out, exp_bits[k-1]);
      check($sformatf("id%0d_done_t%0d", id, k), frame_done, (k == 10));
      check($sformatf("id%0d_busy_t%0d", id, k), busy, 1);
      check($sformatf("id%0d_ready_t%0d", id, k), req_ready, 0);
      if (k == 1) check($sformatf("id%0d_grant_id", id), grant_id, id);
    end
    check($sformatf("id%0d_rx_data", id), bits[7:1], w);
    check($sformatf("id%0d_rx_valid", id),
          (bits[0] == 1'b1) && (bits[9] == 1'b1) && ((^bits[8:1]) == 1'b0), 1);
  endtask

  logic [6:0] rr_words  [4];
  logic       rr_parity [4];

  initial begin
    rstn      = 1'b0;
    req_valid = 4'b0000;
    req_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_channel", channel_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Single request 0x55 from requester 0
    set_word(0, 7'h55);
    req_valid = 4'b0001;
    #1 check("t1_ready", req_ready, 4'b0001);
    expect_frame(7'h55, 2'd0, 1'b0, 4'b0000);
    @(negedge clk);
    #1;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_line", channel_out, 0);
    check("t1_idle_ready", req_ready, 0);

    // Requesters 1 and 3 contend from pointer 0
    do_reset();
    set_word(1, 7'h7F);
    set_word(3, 7'h01);
    req_valid = 4'b1010;
    #1 check("t2_ready_first", req_ready, 4'b0010);
    expect_frame(7'h7F, 2'd1, 1'b1, 4'b1000);
    @(negedge clk);
    #1;
    check("t2_ready_second", req_ready, 4'b1000);
    check("t2_gap_to_idle_line", channel_out, 0);
    expect_frame(7'h01, 2'd3, 1'b1, 4'b0000);
    @(negedge clk);
    #1 check("t2_end_busy", busy, 0);

    // All four held valid: rotation 0,1,2,3,0,1,2,3 with one idle cycle between frames
    do_reset();
    rr_words[0] = 7'h01; rr_parity[0] = 1'b1;
    rr_words[1] = 7'h22; rr_parity[1] = 1'b0;
    rr_words[2] = 7'h07; rr_parity[2] = 1'b1;
    rr_words[3] = 7'h44; rr_parity[3] = 1'b0;
    for (int i = 0; i < 4; i++) set_word(i, rr_words[i]);
    req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      #1;
      check($sformatf("t3_ready_f%0d", f), req_ready, 4'b0001 << (f % 4));
      check($sformatf("t3_idle_busy_f%0d", f), busy, (f == 0) ? 1'b0 : 1'b0);
      expect_frame(rr_words[f % 4], 2'(f % 4), rr_parity[f % 4], (f == 7) ? 4'b0000 : 4'b1111);
      @(negedge clk);
    end
    #1;
    check("t3_end_ready", req_ready, 0);
    check("t3_end_busy", busy, 0);

    // Requester 2 withdraws during requester 0's frame
    do_reset();
    set_word(0, 7'h12);
    set_word(1, 7'h2A);
    set_word(2, 7'h3C);
    req_valid = 4'b0101;
    #1 check("t4_ready_first", req_ready, 4'b0001);
    expect_frame(7'h12, 2'd0, 1'b0, 4'b0010);
    @(negedge clk);
    #1 check("t4_ready_next", req_ready, 4'b0010);
    expect_frame(7'h2A, 2'd1, 1'b1, 4'b0000);
    @(negedge clk);
    #1;
    check("t4_end_ready", req_ready, 0);
    check("t4_end_busy", busy, 0);

    // Reset asserted while data bit 3 is on the wire
    do_reset();
    set_word(2, 7'h0F);
    req_valid = 4'b0100;
    #1 check("t5_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    #1;
    check("t5_bit3_line", channel_out, 1);
    check("t5_bit3_grant_id", grant_id, 2);
    #2 rstn = 1'b0;
    #1;
    check("t5_async_line", channel_out, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_grant_id", grant_id, 0);
    check("t5_async_done", frame_done, 0);
    @(negedge clk);
    rstn = 1'b1;
    set_word(0, 7'h00);
    set_word(3, 7'h7F);
    req_valid = 4'b1001;
    #1 check("t5_ready_after", req_ready, 4'b0001);
    expect_frame(7'h00, 2'd0, 1'b0, 4'b1000);
    @(negedge clk);
    #1 check("t5_ready_second", req_ready, 4'b1000);
    expect_frame(7'h7F, 2'd3, 1'b1, 4'b0000);
    @(negedge clk);
    #1 check("t5_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
